// File: rtl/pipelined_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_adder_if
//   Streaming handshake bundle for pipelined_adder.
//   The N parameter must match the N of the pipelined_adder it is bound to.
//
//   Signals
//     in_valid  : producer offers A/B/sub/cin this cycle
//     in_ready  : adder accepts operands this cycle
//     A, B      : N-bit operands
//     sub       : 0 = add, 1 = subtract
//     cin       : carry-in (add) / borrow-in (subtract)
//     out_valid : R/ovf hold a valid result
//     out_ready : consumer takes the result this cycle
//     R         : N+1-bit result, R[N] = carry-out (subtract: 1 = no borrow)
//     ovf       : signed two's-complement overflow of R[N-1:0]
//
//   Modports
//     master : environment side (producer and consumer)
//     slave  : adder side
// ---------------------------------------------------------------------------
interface pipelined_adder_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   R;
  logic         ovf;

  modport master (
    output in_valid, A, B, sub, cin, out_ready,
    input  in_ready, out_valid, R, ovf
  );

  modport slave (
    input  in_valid, A, B, sub, cin, out_ready,
    output in_ready, out_valid, R, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   Pipelined N-bit adder/subtractor. The operands are split into STAGES
//   segments of SEG = N/STAGES bits; stage k adds segment k and registers its
//   carry into stage k+1. One operation per clock at full throughput, with a
//   valid/ready handshake on both sides. The last stage register is the
//   output register, so latency is STAGES edges including the accept.
//
//   Parameters
//     N      : operand width (>= 1)
//     STAGES : pipeline depth, must divide N exactly
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (clears control and data)
//     bus   : pipelined_adder_if.slave (in_valid/in_ready/A/B/sub/cin,
//             out_valid/out_ready/R/ovf)
// ---------------------------------------------------------------------------
module pipelined_adder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);

  localparam int SEG = N / STAGES;

  // One segment of the carry chain: SEG-bit sum plus carry-out on top.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           c);
    seg_add = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
  endfunction

  // Signed overflow: like-signed operands producing a result of the other sign.
  function automatic logic ovf_flag(input logic a_msb,
                                    input logic bx_msb,
                                    input logic r_msb);
    ovf_flag = (a_msb == bx_msb) && (r_msb != a_msb);
  endfunction

  // Stage 0 has no predecessor; clamp so the unrolled index stays in range.
  function automatic int prev_idx(input int k);
    prev_idx = (k == 0) ? 0 : k - 1;
  endfunction

  logic         adv;
  logic         vld_p  [STAGES];
  logic [N-1:0] a_p    [STAGES];
  logic [N-1:0] bx_p   [STAGES];
  logic [N-1:0] r_p    [STAGES];
  logic         c_p    [STAGES];
  logic         ovf_p;

  logic [N-1:0] a_nx   [STAGES];
  logic [N-1:0] bx_nx  [STAGES];
  logic [N-1:0] r_nx   [STAGES];
  logic         cin_nx [STAGES];
  logic [SEG:0] sum_nx [STAGES];
  logic         ovf_nx;

  // The whole pipe moves as one: bubbles shift too, so the only stall source
  // is a valid result the consumer has not taken.
  assign adv          = !vld_p[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    ovf_nx = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      a_nx[k]   = '0;
      bx_nx[k]  = '0;
      r_nx[k]   = '0;
      cin_nx[k] = 1'b0;
      sum_nx[k] = '0;
    end
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Operand transform: subtract is A + ~B + ~cin.
        a_nx[k]   = bus.A;
        bx_nx[k]  = bus.sub ? ~bus.B : bus.B;
        cin_nx[k] = bus.sub ^ bus.cin;
        r_nx[k]   = '0;
      end else begin
        // Stage boundary k-1 -> k: operands, partial result and carry.
        a_nx[k]   = a_p[prev_idx(k)];
        bx_nx[k]  = bx_p[prev_idx(k)];
        cin_nx[k] = c_p[prev_idx(k)];
        r_nx[k]   = r_p[prev_idx(k)];
      end
      sum_nx[k] = seg_add(a_nx[k][k*SEG +: SEG], bx_nx[k][k*SEG +: SEG], cin_nx[k]);
      r_nx[k][k*SEG +: SEG] = sum_nx[k][SEG-1:0];
    end
    // Last stage: the result MSB is final here, so overflow is resolved here.
    ovf_nx = ovf_flag(a_nx[STAGES-1][N-1], bx_nx[STAGES-1][N-1], r_nx[STAGES-1][N-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        bx_p[k]  <= '0;
        r_p[k]   <= '0;
        c_p[k]   <= 1'b0;
      end
      ovf_p <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= (k == 0) ? bus.in_valid : vld_p[prev_idx(k)];
        a_p[k]   <= a_nx[k];
        bx_p[k]  <= bx_nx[k];
        r_p[k]   <= r_nx[k];
        c_p[k]   <= sum_nx[k][SEG];
      end
      ovf_p <= ovf_nx;
    end
  end

  // Output register is the last stage.
  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.R         = {c_p[STAGES-1], r_p[STAGES-1]};
  assign bus.ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_adder_if #(.N(32)) bus32 ();
  pipelined_adder_if #(.N(8))  bus8 ();

  pipelined_adder #(.N(32), .STAGES(4)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  pipelined_adder #(.N(8), .STAGES(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: result over w+1 bits from plain integer arithmetic.
  function automatic logic [32:0] model_r(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s,
                                          input logic c);
    longint mask, ua, ub, tot;
    logic [32:0] r;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (!s) begin
      tot = ua + ub + longint'(c);
      r   = 33'(tot);
    end else begin
      tot = ua - ub - longint'(c);
      r   = 33'(tot & mask);
      if (tot >= 0) r[w] = 1'b1;   // no borrow
    end
    return r;
  endfunction

  // Reference: true signed result out of w-bit two's-complement range.
  function automatic logic model_ovf(input int w, input logic [31:0] a,
                                     input logic [31:0] b, input logic s,
                                     input logic c);
    longint mask, half, sa, sb, tv;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (sa >= half) sa = sa - 2 * half;
    if (sb >= half) sb = sb - 2 * half;
    tv = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
    return (tv >= half) || (tv < -half);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus32.in_valid = 1'b1;
    bus32.A        = $urandom;
    bus32.B        = $urandom;
    bus32.sub      = 1'b0;
    bus32.cin      = 1'b1;
    bus32.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.A         = 8'hA5;
    bus8.B         = 8'h3C;
    bus8.sub       = 1'b0;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid32: got %b expected 0", bus32.out_valid); end
    n_cmp++; if (bus32.R !== 33'd0) begin n_bad++; $display("FAIL reset_R32: got %h expected 0", bus32.R); end
    n_cmp++; if (bus32.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf32: got %b expected 0", bus32.ovf); end
    n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid8: got %b expected 0", bus8.out_valid); end
    n_cmp++; if (bus8.R !== 9'd0) begin n_bad++; $display("FAIL reset_R8: got %h expected 0", bus8.R); end
    bus32.in_valid = 1'b0;
    bus8.in_valid  = 1'b0;
    rst_n          = 1'b1;
    // Operands offered during reset must not appear after release.
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset cycle %0d: got %b expected 0", i, bus32.out_valid); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [5] = '{32'hFFFFFFFF, 32'h5, 32'h7, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] vb [5] = '{32'h1, 32'h7, 32'h5, 32'h1, 32'h1};
    logic        vs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [32:0] er [5] = '{33'h1_00000000, 33'h0_FFFFFFFE, 33'h1_00000001, 33'h0_80000000, 33'h1_7FFFFFFF};
    logic        eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int cnt;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus32.in_valid = 1'b1;
      bus32.A        = va[i];
      bus32.B        = vb[i];
      bus32.sub      = vs[i];
      bus32.cin      = vc[i];
      tick();
      bus32.in_valid = 1'b0;
      cnt = 1;
      while (bus32.out_valid !== 1'b1 && cnt < 12) begin
        tick();
        cnt++;
      end
      n_cmp++; if (cnt != 4) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d edges expected 4", i, cnt); end
      n_cmp++; if (bus32.R !== er[i]) begin n_bad++; $display("FAIL directed_R[%0d]: got %h expected %h", i, bus32.R, er[i]); end
      n_cmp++; if (bus32.ovf !== eo[i]) begin n_bad++; $display("FAIL directed_ovf[%0d]: got %b expected %b", i, bus32.ovf, eo[i]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_r [$];
    logic        exp_o [$];
    int          sent = 0, got = 0, cyc = 0;
    logic        need_new = 1'b1;
    logic        held = 1'b0;
    logic [32:0] held_r = '0;
    logic        held_o = 1'b0;
    logic [32:0] er;
    logic        eo;
    while (got < 16 && cyc < 400) begin
      if (sent < 16) begin
        if (need_new) begin
          bus32.A   = $urandom;
          bus32.B   = $urandom;
          bus32.sub = 1'($urandom_range(0, 1));
          bus32.cin = 1'($urandom_range(0, 1));
          need_new  = 1'b0;
        end
        bus32.in_valid = 1'b1;
      end else begin
        bus32.in_valid = 1'b0;
      end
      bus32.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        n_cmp++; if (bus32.out_valid !== 1'b1 || bus32.R !== held_r || bus32.ovf !== held_o) begin
          n_bad++; $display("FAIL stall_hold: got v=%b R=%h o=%b expected v=1 R=%h o=%b", bus32.out_valid, bus32.R, bus32.ovf, held_r, held_o);
        end
      end
      n_cmp++; if (bus32.in_ready !== 1'b1 && !(bus32.out_valid === 1'b1 && bus32.out_ready === 1'b0)) begin
        n_bad++; $display("FAIL in_ready_rule: got in_ready=%b with out_valid=%b out_ready=%b", bus32.in_ready, bus32.out_valid, bus32.out_ready);
      end
      if (bus32.out_valid === 1'b1 && bus32.out_ready === 1'b1) begin
        if (exp_r.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL stream_extra: got R=%h expected no result", bus32.R);
        end else begin
          er = exp_r.pop_front();
          eo = exp_o.pop_front();
          n_cmp++; if (bus32.R !== er) begin n_bad++; $display("FAIL stream_R[%0d]: got %h expected %h", got, bus32.R, er); end
          n_cmp++; if (bus32.ovf !== eo) begin n_bad++; $display("FAIL stream_ovf[%0d]: got %b expected %b", got, bus32.ovf, eo); end
        end
        got++;
      end
      if (bus32.in_valid === 1'b1 && bus32.in_ready === 1'b1) begin
        exp_r.push_back(model_r(32, bus32.A, bus32.B, bus32.sub, bus32.cin));
        exp_o.push_back(model_ovf(32, bus32.A, bus32.B, bus32.sub, bus32.cin));
        sent++;
        need_new = 1'b1;
      end
      held   = (bus32.out_valid === 1'b1) && (bus32.out_ready === 1'b0);
      held_r = bus32.R;
      held_o = bus32.ovf;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++; if (got != 16) begin n_bad++; $display("FAIL stream_count: got %0d results expected 16", got); end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_duplicate cycle %0d: got out_valid=%b expected 0", i, bus32.out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] xa, xb;
    logic        xs, xc;
    int          cnt;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus32.in_valid = 1'b1;
      bus32.A        = $urandom;
      bus32.B        = $urandom;
      bus32.sub      = 1'($urandom_range(0, 1));
      bus32.cin      = 1'($urandom_range(0, 1));
      tick();
    end
    bus32.in_valid = 1'b0;
    n_cmp++; if (bus32.out_valid !== 1'b1) begin n_bad++; $display("FAIL fill_valid: got %b expected 1", bus32.out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b expected 0", bus32.out_valid); end
    n_cmp++; if (bus32.R !== 33'd0) begin n_bad++; $display("FAIL midreset_R: got %h expected 0", bus32.R); end
    n_cmp++; if (bus32.ovf !== 1'b0) begin n_bad++; $display("FAIL midreset_ovf: got %b expected 0", bus32.ovf); end
    tick();
    tick();
    rst_n = 1'b1;
    xa = $urandom; xb = $urandom; xs = 1'b1; xc = 1'b0;
    bus32.in_valid = 1'b1;
    bus32.A = xa; bus32.B = xb; bus32.sub = xs; bus32.cin = xc;
    tick();
    bus32.in_valid = 1'b0;
    cnt = 1;
    while (bus32.out_valid !== 1'b1 && cnt < 12) begin
      tick();
      cnt++;
    end
    n_cmp++; if (cnt != 4) begin n_bad++; $display("FAIL postreset_latency: got %0d edges expected 4", cnt); end
    n_cmp++; if (bus32.R !== model_r(32, xa, xb, xs, xc)) begin n_bad++; $display("FAIL postreset_R: got %h expected %h", bus32.R, model_r(32, xa, xb, xs, xc)); end
    tick();
  endtask

  task automatic test_single_stage();
    logic [8:0] er;
    logic       eo;
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.sub = 1'b0; bus8.cin = 1'b1;
    tick();
    n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL s1_valid: got %b expected 1", bus8.out_valid); end
    n_cmp++; if (bus8.R !== 9'h1FF) begin n_bad++; $display("FAIL s1_R: got %h expected 1ff", bus8.R); end
    n_cmp++; if (bus8.ovf !== 1'b0) begin n_bad++; $display("FAIL s1_ovf: got %b expected 0", bus8.ovf); end
    for (int i = 0; i < 8; i++) begin
      bus8.A   = 8'($urandom);
      bus8.B   = 8'($urandom);
      bus8.sub = 1'($urandom_range(0, 1));
      bus8.cin = 1'($urandom_range(0, 1));
      er = 9'(model_r(8, 32'(bus8.A), 32'(bus8.B), bus8.sub, bus8.cin));
      eo = model_ovf(8, 32'(bus8.A), 32'(bus8.B), bus8.sub, bus8.cin);
      tick();
      n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.R !== er) begin n_bad++; $display("FAIL s1_rand_R[%0d]: got v=%b R=%h expected v=1 R=%h", i, bus8.out_valid, bus8.R, er); end
      n_cmp++; if (bus8.ovf !== eo) begin n_bad++; $display("FAIL s1_rand_ovf[%0d]: got %b expected %b", i, bus8.ovf, eo); end
    end
    bus8.in_valid = 1'b0;
    tick();
    n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL s1_drain: got %b expected 0", bus8.out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
